// File: rtl/pixel_arb_pkg.sv
// Shared types and defaults for the frame-granular pixel source arbiter.
package pixel_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STREAM,
        DRAIN
    } arb_state_t;

    localparam int DEF_DATA_W   = 12;
    localparam int DEF_H_ACTIVE = 1280;
    localparam int DEF_V_ACTIVE = 720;
    localparam int FRAME_PIXELS = DEF_H_ACTIVE * DEF_V_ACTIVE;

    // A one-pixel frame still needs a one-bit counter.
    function automatic int cnt_width(int pixels);
        return (pixels > 1) ? $clog2(pixels) : 1;
    endfunction

    localparam int FRAME_CNT_W = cnt_width(FRAME_PIXELS);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_SRC = 2,
    parameter int SEL_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [NUM_SRC-1:0] grant,
    output logic [SEL_W-1:0]   grant_idx,
    output logic               any_req
);

    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            int j;
            j = int'(ptr) + k;
            if (j >= NUM_SRC) j = j - NUM_SRC;
            if (!found && req[j]) begin
                found     = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = SEL_W'(j);
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/pixel_source_arbiter.sv
// Shares one pixel write port between NUM_SRC sources, one whole frame per grant.
// Optional BLANK_FILL_EN: feed black pixels to the sink while idle with no requester.
module pixel_source_arbiter
    import pixel_arb_pkg::*;
#(
    parameter int NUM_SRC  = 2,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int DATA_W   = DEF_DATA_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_SRC-1:0]          src_req,
    output logic [NUM_SRC-1:0]          src_can_write,
    output logic [NUM_SRC-1:0]          src_reset,
    input  logic [NUM_SRC*DATA_W-1:0]   src_write_data,
    input  logic [NUM_SRC-1:0]          src_write_ready,
    input  logic                        sink_can_write,
    output logic [DATA_W-1:0]           sink_write_data,
    output logic                        sink_write_ready,
    output logic [$clog2(NUM_SRC)-1:0]  active_src,
    output logic                        busy,
    output logic                        frame_done
);

    localparam int SEL_W = $clog2(NUM_SRC);
    localparam int FRAME = H_ACTIVE * V_ACTIVE;
    localparam int CNT_W = cnt_width(FRAME);
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME - 1);
    localparam logic [SEL_W-1:0] LAST_SRC = SEL_W'(NUM_SRC - 1);

    arb_state_t state, state_next;

    logic [CNT_W-1:0]   issue_cnt;
    logic [1:0]         outstanding;
    logic [SEL_W-1:0]   rr_ptr;
    logic [SEL_W-1:0]   grant_idx;
    logic [NUM_SRC-1:0] grant;
    logic               any_req;
    logic               issue;
    logic               accept;
    logic               done;
    logic               fill;
    logic               ready_act;
    logic [DATA_W-1:0]  data_act;

    rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
    ) u_rr (
        .req       (src_req),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_req   (any_req)
    );

    assign ready_act = src_write_ready[active_src];
    assign data_act  = src_write_data[active_src*DATA_W +: DATA_W];

    // Only the granted source's returns are accepted, and only mid-frame.
    assign accept = ready_act &&
                    (state == STREAM || state == DRAIN);

`ifdef BLANK_FILL_EN
    assign fill = (state == IDLE) && !any_req && sink_can_write;
`else
    assign fill = 1'b0;
`endif

    always_comb begin
        state_next    = state;
        src_can_write = '0;
        src_reset     = '0;
        issue         = 1'b0;
        done          = 1'b0;
        unique case (state)
            IDLE: begin
                if (|grant) state_next = LOAD;
            end
            LOAD: begin
                src_reset[active_src] = 1'b1;
                state_next = STREAM;
            end
            STREAM: begin
                src_can_write[active_src] = sink_can_write;
                issue = sink_can_write;
                if (issue && issue_cnt == LAST_PIX)
                    state_next = DRAIN;
            end
            DRAIN: begin
                if (outstanding == 2'd0 && !ready_act) begin
                    done = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy       = (state != IDLE);
    assign frame_done = done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            issue_cnt   <= '0;
            outstanding <= 2'd0;
            rr_ptr      <= '0;
            active_src  <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && |grant)
                active_src <= grant_idx;
            if (state == LOAD)
                issue_cnt <= '0;
            else if (issue)
                issue_cnt <= issue_cnt + 1'b1;
            case ({issue, accept})
                2'b10:   outstanding <= outstanding + 2'd1;
                2'b01:   outstanding <= outstanding - 2'd1;
                default: outstanding <= outstanding;
            endcase
            if (done)
                rr_ptr <= (active_src == LAST_SRC) ? '0 : active_src + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sink_write_ready <= 1'b0;
            sink_write_data  <= '0;
        end else begin
            sink_write_ready <= accept || fill;
            sink_write_data  <= accept ? data_act : '0;
        end
    end

endmodule

// File: tb/tb_pixel_source_arbiter.sv
// Self-checking bench for pixel_source_arbiter with 4x2 frames and two sources.
// Define BLANK_FILL_EN for both bench and RTL to exercise idle blank fill.
module tb_pixel_source_arbiter;

    localparam int N  = 2;
    localparam int DW = 12;
    localparam int FP = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    src_req = '0;
    logic [N-1:0]    src_can_write;
    logic [N-1:0]    src_reset;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    wready;
    logic            sink_can_write = 1'b1;
    logic [DW-1:0]   sink_write_data;
    logic            sink_write_ready;
    logic [0:0]      active_src;
    logic            busy;
    logic            frame_done;

    pixel_source_arbiter #(
        .NUM_SRC  (N),
        .H_ACTIVE (4),
        .V_ACTIVE (2),
        .DATA_W   (DW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .src_req          (src_req),
        .src_can_write    (src_can_write),
        .src_reset        (src_reset),
        .src_write_data   (wdata),
        .src_write_ready  (wready),
        .sink_can_write   (sink_can_write),
        .sink_write_data  (sink_write_data),
        .sink_write_ready (sink_write_ready),
        .active_src       (active_src),
        .busy             (busy),
        .frame_done       (frame_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    function automatic void chk(bit ok, string name, int act, int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Source model: restarts at pixel 0 on src_reset, answers one cycle after can_write.
    logic [7:0] pix [N];
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (reset) begin
                wready[i] <= 1'b0;
                pix[i]    <= 8'd0;
            end else begin
                wready[i] <= src_can_write[i];
                if (src_reset[i]) begin
                    pix[i] <= 8'd0;
                end else if (src_can_write[i]) begin
                    wdata[i*DW +: DW] <= {4'(i + 1), pix[i]};
                    pix[i] <= pix[i] + 8'd1;
                end
            end
        end
    end

    // Sink back-pressure: constant 1, or the repeating pattern 1,0,0,1.
    bit         toggle = 1'b0;
    logic [3:0] pat = 4'b1001;
    int         ph = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (toggle) begin
                sink_can_write = pat[ph];
                ph = (ph + 1) % 4;
            end else begin
                sink_can_write = 1'b1;
            end
        end
    end

    // Scoreboard and monitor, sampled on the falling edge.
    logic [DW-1:0] q[$];
    int            grants[$];
    int            cyc = 0;
    int            frames = 0;
    int            frame_issue = 0;
    int            last_issue = 0;
    int            req_cyc = 0;
    int            fills = 0;
    bit            chk_lat = 1'b0;
    bit            prev_busy = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            q.delete();
            frame_issue = 0;
            prev_busy = 1'b0;
        end else begin
            if (|src_reset) begin
                int g;
                g = src_reset[1] ? 1 : 0;
                grants.push_back(g);
                chk(int'(active_src) == g, "grant_active_src", active_src, g);
                if (chk_lat) begin
                    chk(cyc == req_cyc + 2, "reset_latency", cyc - req_cyc, 2);
                    chk_lat = 1'b0;
                end
                frame_issue = 0;
            end
            if (|src_can_write) begin
                int idx;
                idx = src_can_write[1] ? 1 : 0;
                chk($countones(src_can_write) == 1, "can_write_onehot",
                    src_can_write, 1);
                chk(idx == int'(active_src), "can_write_owner", idx, active_src);
                q.push_back({4'(idx + 1), 8'(frame_issue)});
                frame_issue++;
                last_issue = cyc;
            end
            if (sink_write_ready) begin
                if (q.size() == 0) begin
`ifdef BLANK_FILL_EN
                    chk(!prev_busy && sink_write_data == '0, "blank_fill",
                        sink_write_data, 0);
                    fills++;
`else
                    chk(1'b0, "unexpected_pixel", sink_write_data, 0);
`endif
                end else begin
                    logic [DW-1:0] e;
                    e = q.pop_front();
                    chk(sink_write_data == e, "pixel_data", sink_write_data, e);
                end
            end
            if (frame_done) begin
                frames++;
                chk(frame_issue == FP, "issues_per_frame", frame_issue, FP);
                chk(cyc == last_issue + 2, "done_latency", cyc - last_issue, 2);
                chk(q.size() == 0, "drained_at_done", q.size(), 0);
            end
            prev_busy = busy;
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        src_req = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        grants.delete();
        frames = 0;
        req_cyc = cyc;
        chk_lat = 1'b1;
    endtask

    task automatic wait_frames(int n, int budget);
        for (int i = 0; i < budget && frames < n; i++) @(posedge clk);
        #1;
        chk(frames >= n, "frame_timeout", frames, n);
    endtask

    task automatic wait_issues(int n, int budget);
        int i;
        for (i = 0; i < budget && frame_issue < n; i++) begin
            @(negedge clk);
            #1;
        end
        chk(frame_issue >= n, "issue_timeout", frame_issue, n);
    endtask

    typedef struct {
        logic [1:0] req;
        bit         tog;
        int         nfr;
        logic [3:0] exp_g;
    } vec_t;

    vec_t vecs [5];

    initial begin
        // exp_g bit k is the source expected to win frame k.
        vecs[0] = '{req: 2'b01, tog: 1'b0, nfr: 2, exp_g: 4'b0000};
        vecs[1] = '{req: 2'b11, tog: 1'b0, nfr: 4, exp_g: 4'b1010};
        vecs[2] = '{req: 2'b10, tog: 1'b0, nfr: 1, exp_g: 4'b0001};
        vecs[3] = '{req: 2'b11, tog: 1'b1, nfr: 2, exp_g: 4'b0010};
        vecs[4] = '{req: 2'b01, tog: 1'b1, nfr: 1, exp_g: 4'b0000};

        repeat (2) @(posedge clk);
        #1;
        chk(src_can_write == '0, "rst_can_write", src_can_write, 0);
        chk(src_reset == '0, "rst_src_reset", src_reset, 0);
        chk(sink_write_ready == 1'b0, "rst_sink_ready", sink_write_ready, 0);
        chk(sink_write_data == '0, "rst_sink_data", sink_write_data, 0);
        chk(active_src == '0, "rst_active_src", active_src, 0);
        chk(busy == 1'b0 && frame_done == 1'b0, "rst_busy_done",
            {busy, frame_done}, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk(busy == 1'b0, "idle_busy", busy, 0);
`ifndef BLANK_FILL_EN
        chk(sink_write_ready == 1'b0, "idle_no_output", sink_write_ready, 0);
`endif

        for (int v = 0; v < 5; v++) begin
            do_reset();
            toggle = vecs[v].tog;
            src_req = vecs[v].req;
            wait_frames(vecs[v].nfr, 60 * vecs[v].nfr);
            src_req = '0;
            for (int k = 0; k < vecs[v].nfr; k++) begin
                int e;
                e = vecs[v].exp_g[k] ? 1 : 0;
                chk(k < grants.size() && grants[k] == e, "grant_order",
                    (k < grants.size()) ? grants[k] : -1, e);
            end
        end
        toggle = 1'b0;

        // Source 1 withdraws its request mid-frame; the frame must still finish.
        do_reset();
        src_req = 2'b10;
        wait_issues(3, 40);
        src_req = '0;
        wait_frames(1, 60);
        repeat (6) @(posedge clk);
        #1;
        chk(busy == 1'b0, "drop_req_idle", busy, 0);
        chk(frames == 1, "drop_req_frames", frames, 1);
        chk(grants.size() == 1 && grants[0] == 1, "drop_req_grant",
            grants.size(), 1);

        // Reset in the middle of a frame discards in-flight pixels.
        do_reset();
        src_req = 2'b01;
        wait_issues(5, 40);
        reset = 1'b1;
        src_req = '0;
        @(posedge clk);
        #1;
        chk(src_can_write == '0, "midrst_can_write", src_can_write, 0);
        chk(src_reset == '0, "midrst_src_reset", src_reset, 0);
        chk(sink_write_ready == 1'b0, "midrst_sink_ready", sink_write_ready, 0);
        chk(busy == 1'b0 && frame_done == 1'b0, "midrst_busy_done",
            {busy, frame_done}, 0);
        chk(active_src == '0, "midrst_active_src", active_src, 0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
`ifdef BLANK_FILL_EN
            chk(sink_write_data == '0, "midrst_no_forward", sink_write_data, 0);
`else
            chk(sink_write_ready == 1'b0, "midrst_no_forward",
                sink_write_ready, 0);
`endif
        end
        chk(frames == 0, "midrst_no_done", frames, 0);

`ifdef BLANK_FILL_EN
        // Idle fill runs until a request is seen, then stops before LOAD.
        do_reset();
        chk_lat = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk(sink_write_ready == 1'b1 && sink_write_data == '0,
                "fill_active", sink_write_ready, 1);
        end
        @(posedge clk);
        #1;
        src_req = 2'b01;
        @(negedge clk);
        @(negedge clk);
        chk(sink_write_ready == 1'b0, "fill_stops", sink_write_ready, 0);
        chk(frames == 0, "fill_no_done", frames, 0);
        chk(fills >= 3, "fill_count", fills, 3);
        wait_frames(1, 60);
        src_req = '0;
`endif

        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
